// File: rtl/riscv_pkg.sv
// Shared definitions for the multi-cycle RV32I control path: FSM states,
// opcodes, ALU operation codes and datapath select encodings.
package riscv_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10
   } state_t;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;
   localparam logic [2:0] ALU_SLL = 3'b100;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_MEMDATA   = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/alu_decoder.sv
// Maps funct3/funct7b5 of an ALU instruction to the ALU operation code and
// flags funct3 values the datapath does not implement.
module alu_decoder
   import riscv_pkg::*;
(
   input  logic [2:0] i_funct3,
   input  logic       i_funct7b5,
   input  logic       i_is_rtype,
   output logic [2:0] o_alu_control,
   output logic       o_legal
);

   // funct3 decode; SUB exists only for R-type (addi has no subtract form)
   always_comb begin
      o_alu_control = ALU_ADD;
      o_legal       = 1'b1;
      case (i_funct3)
         3'b000:  o_alu_control = (i_is_rtype && i_funct7b5) ? ALU_SUB : ALU_ADD;
         3'b001:  o_alu_control = ALU_SLL;
         3'b010:  o_alu_control = ALU_SLT;
         3'b110:  o_alu_control = ALU_OR;
         3'b111:  o_alu_control = ALU_AND;
         default: o_legal       = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for the multi-cycle RV32I datapath. Outputs stay quiet
// until the first clock edge after reset release, then FETCH is presented.
module multicycle_control
   import riscv_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   output logic       pc_write,
   output logic       adr_src,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_write,
   output logic [1:0] result_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] imm_src,
   output logic [2:0] alu_control,
   output logic       illegal,
   output logic       instr_done
);

   state_t     r_state;
   state_t     w_state_next;
   logic       r_run;
   logic       w_is_r;
   logic       w_is_i;
   logic       w_alu_legal;
   logic [2:0] w_dec_alu;

   assign w_is_r = (opcode == OP_R);
   assign w_is_i = (opcode == OP_I);

   alu_decoder u_alu_decoder (
      .i_funct3      (funct3),
      .i_funct7b5    (funct7b5),
      .i_is_rtype    (w_is_r),
      .o_alu_control (w_dec_alu),
      .o_legal       (w_alu_legal)
   );

   // State register; r_run holds the FSM in FETCH until the first edge after release
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_FETCH;
         r_run   <= 1'b0;
      end else begin
         r_run <= 1'b1;
         if (r_run)
            r_state <= w_state_next;
      end
   end

   // Next-state sequencing
   always_comb begin
      w_state_next = S_FETCH;
      case (r_state)
         S_FETCH:  w_state_next = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: w_state_next = S_MEMADR;
               OP_R:         w_state_next = w_alu_legal ? S_EXECR : S_FETCH;
               OP_I:         w_state_next = w_alu_legal ? S_EXECI : S_FETCH;
               OP_BEQ:       w_state_next = S_BEQ;
               OP_JAL:       w_state_next = S_JAL;
               default:      w_state_next = S_FETCH;
            endcase
         end
         S_MEMADR:   w_state_next = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  w_state_next = S_MEMWB;
         S_EXECR:    w_state_next = S_ALUWB;
         S_EXECI:    w_state_next = S_ALUWB;
         S_JAL:      w_state_next = S_ALUWB;
         default:    w_state_next = S_FETCH;
      endcase
   end

   // Per-state outputs, all forced inactive while the FSM is not running
   always_comb begin
      pc_write    = 1'b0;
      adr_src     = 1'b0;
      mem_write   = 1'b0;
      ir_write    = 1'b0;
      reg_write   = 1'b0;
      result_src  = RES_ALUOUT;
      alu_src_a   = SRCA_PC;
      alu_src_b   = SRCB_RS2;
      imm_src     = IMM_I;
      alu_control = ALU_ADD;
      illegal     = 1'b0;
      instr_done  = 1'b0;
      if (r_run) begin
         case (opcode)
            OP_SW:   imm_src = IMM_S;
            OP_BEQ:  imm_src = IMM_B;
            OP_JAL:  imm_src = IMM_J;
            default: imm_src = IMM_I;
         endcase
         case (r_state)
            S_FETCH: begin
               ir_write   = 1'b1;
               alu_src_b  = SRCB_FOUR;
               result_src = RES_ALURESULT;
               pc_write   = 1'b1;
            end
            S_DECODE: begin
               alu_src_a = SRCA_OLDPC;
               alu_src_b = SRCB_IMM;
               case (opcode)
                  OP_LW, OP_SW, OP_BEQ, OP_JAL: illegal = 1'b0;
                  OP_R, OP_I:                   illegal = ~w_alu_legal;
                  default:                      illegal = 1'b1;
               endcase
            end
            S_MEMADR: begin
               alu_src_a = SRCA_RS1;
               alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: adr_src = 1'b1;
            S_MEMWB: begin
               result_src = RES_MEMDATA;
               reg_write  = 1'b1;
               instr_done = 1'b1;
            end
            S_MEMWRITE: begin
               adr_src    = 1'b1;
               mem_write  = 1'b1;
               instr_done = 1'b1;
            end
            S_EXECR: begin
               alu_src_a   = SRCA_RS1;
               alu_src_b   = SRCB_RS2;
               alu_control = w_dec_alu;
            end
            S_EXECI: begin
               alu_src_a   = SRCA_RS1;
               alu_src_b   = SRCB_IMM;
               alu_control = w_dec_alu;
            end
            S_ALUWB: begin
               reg_write  = 1'b1;
               instr_done = 1'b1;
            end
            S_BEQ: begin
               alu_src_a   = SRCA_RS1;
               alu_src_b   = SRCB_RS2;
               alu_control = ALU_SUB;
               pc_write    = zero;
               instr_done  = 1'b1;
            end
            S_JAL: begin
               alu_src_a = SRCA_OLDPC;
               alu_src_b = SRCB_FOUR;
               pc_write  = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: the stimulus process pushes the
// hand-derived expected output vector of every cycle; the monitor pops and
// compares on each falling edge.
module tb_multicycle_control;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       zero;
   logic       pc_write, adr_src, mem_write, ir_write, reg_write;
   logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
   logic [2:0] alu_control;
   logic       illegal, instr_done;

   typedef struct {
      string      nm;
      logic [17:0] v;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   // Vector layout: pcw adr mw irw rw | rs sa sb imm | alu | ill done
   localparam logic [17:0] RESET_VEC = {5'b00000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b010, 2'b00};

   multicycle_control dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
      .funct7b5(funct7b5), .zero(zero), .pc_write(pc_write),
      .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
      .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .imm_src(imm_src), .alu_control(alu_control),
      .illegal(illegal), .instr_done(instr_done)
   );

   always #5 clk = ~clk;

   function automatic logic [17:0] actual_vec();
      return {pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
              alu_src_a, alu_src_b, imm_src, alu_control, illegal, instr_done};
   endfunction

   task automatic check_vec(input string nm, input logic [17:0] want);
      logic [17:0] got;
      got = actual_vec();
      n_checks++;
      if (got === want) begin
         n_pass++;
         $display("ok   %-24s out=%b", nm, got);
      end else
         $display("FAIL %-24s got=%b want=%b", nm, got, want);
   endtask

   // Monitor: every cycle with a pending expectation is compared mid-cycle
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check_vec(e.nm, e.v);
      end
   end

   // Queue one cycle's expected outputs, then advance to just after the next edge
   task automatic step(input string nm, input logic pcw, adr, mw, irw, rw,
                       input logic [1:0] rs, sa, sb, imm,
                       input logic [2:0] alu, input logic ill, done);
      exp_t e;
      e.nm = nm;
      e.v  = {pcw, adr, mw, irw, rw, rs, sa, sb, imm, alu, ill, done};
      exp_q.push_back(e);
      @(posedge clk); #1;
   endtask

   task automatic set_ir(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic z);
      opcode = op; funct3 = f3; funct7b5 = f7; zero = z;
   endtask

   // R-type / I-type ALU instruction: FETCH, DECODE, EXEC, ALUWB
   task automatic alu_instr(input string nm, input logic [6:0] op, input logic [2:0] f3,
                            input logic f7, input logic [2:0] want_alu);
      set_ir(op, f3, f7, 1'b0);
      step({nm, " FETCH"},  1,0,0,1,0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b010, 0,0);
      step({nm, " DECODE"}, 0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b010, 0,0);
      if (op == 7'b0110011)
         step({nm, " EXECR"}, 0,0,0,0,0, 2'b00, 2'b10, 2'b00, 2'b00, want_alu, 0,0);
      else
         step({nm, " EXECI"}, 0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b00, want_alu, 0,0);
      step({nm, " ALUWB"},  0,0,0,0,1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b010, 0,1);
   endtask

   task automatic illegal_instr(input string nm, input logic [6:0] op, input logic [2:0] f3);
      set_ir(op, f3, 1'b0, 1'b0);
      step({nm, " FETCH"},  1,0,0,1,0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b010, 0,0);
      step({nm, " DECODE"}, 0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b010, 1,0);
   endtask

   task automatic beq_instr(input string nm, input logic z);
      set_ir(7'b1100011, 3'b000, 1'b0, z);
      step({nm, " FETCH"},  1,0,0,1,0, 2'b10, 2'b00, 2'b10, 2'b10, 3'b010, 0,0);
      step({nm, " DECODE"}, 0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b10, 3'b010, 0,0);
      step({nm, " BEQ"},    z,0,0,0,0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b110, 0,1);
   endtask

   initial begin
      rst_n = 1'b0;
      set_ir(7'b0110011, 3'b000, 1'b0, 1'b0);
      @(posedge clk); #1;
      step("reset held", 0,0,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b010, 0,0);
      rst_n = 1'b1;
      step("released idle", 0,0,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b010, 0,0);

      alu_instr("sub",  7'b0110011, 3'b000, 1'b1, 3'b110);
      alu_instr("sll",  7'b0110011, 3'b001, 1'b0, 3'b100);
      alu_instr("and",  7'b0110011, 3'b111, 1'b0, 3'b000);
      alu_instr("addi", 7'b0010011, 3'b000, 1'b1, 3'b010);
      alu_instr("slti", 7'b0010011, 3'b010, 1'b0, 3'b111);
      alu_instr("ori",  7'b0010011, 3'b110, 1'b0, 3'b001);

      set_ir(7'b0000011, 3'b010, 1'b0, 1'b0);
      step("lw FETCH",   1,0,0,1,0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b010, 0,0);
      step("lw DECODE",  0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b010, 0,0);
      step("lw MEMADR",  0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b010, 0,0);
      step("lw MEMREAD", 0,1,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b010, 0,0);
      step("lw MEMWB",   0,0,0,0,1, 2'b01, 2'b00, 2'b00, 2'b00, 3'b010, 0,1);

      set_ir(7'b0100011, 3'b010, 1'b0, 1'b0);
      step("sw FETCH",    1,0,0,1,0, 2'b10, 2'b00, 2'b10, 2'b01, 3'b010, 0,0);
      step("sw DECODE",   0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b01, 3'b010, 0,0);
      step("sw MEMADR",   0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b01, 3'b010, 0,0);
      step("sw MEMWRITE", 0,1,1,0,0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b010, 0,1);

      beq_instr("beq taken", 1'b1);
      beq_instr("beq not",   1'b0);

      set_ir(7'b1101111, 3'b000, 1'b0, 1'b0);
      step("jal FETCH",  1,0,0,1,0, 2'b10, 2'b00, 2'b10, 2'b11, 3'b010, 0,0);
      step("jal DECODE", 0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b11, 3'b010, 0,0);
      step("jal JAL",    1,0,0,0,0, 2'b00, 2'b01, 2'b10, 2'b11, 3'b010, 0,0);
      step("jal ALUWB",  0,0,0,0,1, 2'b00, 2'b00, 2'b00, 2'b11, 3'b010, 0,1);

      illegal_instr("lui",      7'b0110111, 3'b000);
      illegal_instr("r f3=100", 7'b0110011, 3'b100);

      // Store aborted by reset in its MEMWRITE cycle
      set_ir(7'b0100011, 3'b010, 1'b0, 1'b0);
      step("swab FETCH",  1,0,0,1,0, 2'b10, 2'b00, 2'b10, 2'b01, 3'b010, 0,0);
      step("swab DECODE", 0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b01, 3'b010, 0,0);
      step("swab MEMADR", 0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b01, 3'b010, 0,0);
      begin
         exp_t e;
         e.nm = "swab MEMWRITE";
         e.v  = {5'b01100, 2'b00, 2'b00, 2'b00, 2'b01, 3'b010, 2'b01};
         exp_q.push_back(e);
      end
      @(negedge clk); #1;
      rst_n = 1'b0;
      #1;
      check_vec("swab reset immediate", RESET_VEC);
      @(posedge clk); #1;
      step("swab reset held", 0,0,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b010, 0,0);
      rst_n = 1'b1;
      step("swab released",   0,0,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b010, 0,0);
      alu_instr("post-reset sub", 7'b0110011, 3'b000, 1'b1, 3'b110);

      @(negedge clk); #1;
      n_checks++;
      if (exp_q.size() == 0)
         n_pass++;
      else
         $display("FAIL queue drain: %0d left, want 0", exp_q.size());

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Hard time limit so the run always terminates
   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
